// File: rtl/moa_pkg.sv
// Shared elaboration-time helpers for the multi-operand adder: parameter legality
// checks and derivation of result width, latency and compressor level count.
package moa_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  function automatic bit legal_num_ops(input int n);
    return (n == 4) || (n == 8) || (n == 16);
  endfunction

  function automatic bit legal_width(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

  function automatic int lat_of(input int n);
    int l;
    l = 0;
    for (int i = 0; i < 6; i++) begin
      if ((1 << i) < n) l = i + 1;
    end
    return l;
  endfunction

  function automatic int ow_of(input int n, input int w);
    return w + lat_of(n);
  endfunction

  // Each 4:2 level halves the row count; the last two rows go to the final adder.
  function automatic int levels_of(input int n);
    return lat_of(n) - 1;
  endfunction

endpackage

// File: rtl/cprs_4_2_cell.sv
// Single-bit 4:2 compressor: x0+x1+x2+x3+cin = sum + 2*(carry+cout).
// cout depends only on x0..x2, so the horizontal chain never ripples.
module cprs_4_2_cell (
  input  logic x0_i,
  input  logic x1_i,
  input  logic x2_i,
  input  logic x3_i,
  input  logic cin_i,
  output logic sum_o,
  output logic carry_o,
  output logic cout_o
);

  logic s1;

  assign s1      = x0_i ^ x1_i ^ x2_i;
  assign cout_o  = (x0_i & x1_i) | (x0_i & x2_i) | (x1_i & x2_i);
  assign sum_o   = s1 ^ x3_i ^ cin_i;
  assign carry_o = (s1 & x3_i) | (s1 & cin_i) | (x3_i & cin_i);

endmodule

// File: rtl/moa_cprs_tree.sv
// Pipelined multi-operand adder: input register, levels of 4:2 compressors each
// followed by a register, and a final carry-propagate adder into sum_o.
module moa_cprs_tree
  import moa_pkg::*;
#(
  parameter  int NUM_OPS = 8,
  parameter  int WIDTH   = 8,
  parameter  int SIGNED  = 0,
  localparam int OW      = ow_of(NUM_OPS, WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] ops_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            sum_o,
  output logic                     busy
);

  localparam int LAT    = lat_of(NUM_OPS);
  localparam int LEVELS = levels_of(NUM_OPS);

  if (!legal_num_ops(NUM_OPS) || !legal_width(WIDTH) || (SIGNED != 0 && SIGNED != 1)) begin : g_bad_param
    $error("moa_cprs_tree: illegal NUM_OPS/WIDTH/SIGNED parameter value");
  end

  logic            en;
  logic            out_valid_q;
  logic [OW-1:0]   sum_q;
  logic [LEVELS:0] stg_v;

  // The whole pipeline advances together; only a held result blocks it.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign sum_o     = sum_q;
  assign busy      = (|stg_v) | out_valid_q;

  for (genvar gi = 0; gi <= LEVELS; gi++) begin : g_stg
    localparam int ROWS = NUM_OPS >> gi;

    logic [OW-1:0] row_d [ROWS];
    logic [OW-1:0] row_q [ROWS];
    logic          v_d;
    logic          v_q;

    if (gi == 0) begin : g_in
      for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
        logic [WIDTH-1:0] op;
        assign op       = ops_i[k*WIDTH +: WIDTH];
        assign row_d[k] = {{LAT{(SIGNED != 0) & op[WIDTH-1]}}, op};
      end
      assign v_d = in_valid;
    end else begin : g_lvl
      for (genvar g = 0; g < ROWS / 2; g++) begin : g_grp
        logic [OW-1:0] s_w;
        logic [OW:0]   c_w;
        logic [OW:0]   ci_w;
        logic          unused_top_w;

        assign ci_w[0] = 1'b0;
        assign c_w[0]  = 1'b0;

        for (genvar b = 0; b < OW; b++) begin : g_bit
          cprs_4_2_cell u_cell (
            .x0_i   (g_stg[gi-1].row_q[4*g+0][b]),
            .x1_i   (g_stg[gi-1].row_q[4*g+1][b]),
            .x2_i   (g_stg[gi-1].row_q[4*g+2][b]),
            .x3_i   (g_stg[gi-1].row_q[4*g+3][b]),
            .cin_i  (ci_w[b]),
            .sum_o  (s_w[b]),
            .carry_o(c_w[b+1]),
            .cout_o (ci_w[b+1])
          );
        end

        // Bits shifted past the MSB carry weight 2^OW and vanish modulo 2^OW.
        assign unused_top_w = ci_w[OW] ^ c_w[OW];
        assign row_d[2*g]   = s_w;
        assign row_d[2*g+1] = c_w[OW-1:0];
      end
      assign v_d = g_stg[gi-1].v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        for (int r = 0; r < ROWS; r++) row_q[r] <= '0;
      end else if (en) begin
        v_q <= v_d;
        for (int r = 0; r < ROWS; r++) row_q[r] <= row_d[r];
      end
    end

    assign stg_v[gi] = v_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
    end else if (en) begin
      out_valid_q <= g_stg[LEVELS].v_q;
      sum_q       <= g_stg[LEVELS].row_q[0] + g_stg[LEVELS].row_q[1];
    end
  end

endmodule

// File: tb/tb_moa_cprs_tree.sv
// Directed bench for moa_cprs_tree: table vectors with latency checks, a random
// stream against a reference sum, stall, reset-abort, and 4/16-operand builds.
module tb_moa_cprs_tree;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] ops = '0;
  logic        in_ready_u, ov_u, busy_u;
  logic [10:0] sum_u;
  logic        in_ready_s, ov_s, busy_s;
  logic [10:0] sum_s;

  logic         iv4 = 1'b0, iv16 = 1'b0;
  logic         ordy_x = 1'b1;
  logic [31:0]  ops4 = '0;
  logic [127:0] ops16 = '0;
  logic         ir4, ov4, busy4, ir16, ov16, busy16;
  logic [9:0]   sum4;
  logic [11:0]  sum16;

  moa_cprs_tree #(.NUM_OPS(8), .WIDTH(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .ops_i(ops),
    .out_valid(ov_u), .out_ready(out_ready), .sum_o(sum_u), .busy(busy_u));

  moa_cprs_tree #(.NUM_OPS(8), .WIDTH(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .ops_i(ops),
    .out_valid(ov_s), .out_ready(out_ready), .sum_o(sum_s), .busy(busy_s));

  moa_cprs_tree #(.NUM_OPS(4), .WIDTH(8), .SIGNED(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .ops_i(ops4),
    .out_valid(ov4), .out_ready(ordy_x), .sum_o(sum4), .busy(busy4));

  moa_cprs_tree #(.NUM_OPS(16), .WIDTH(8), .SIGNED(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .ops_i(ops16),
    .out_valid(ov16), .out_ready(ordy_x), .sum_o(sum16), .busy(busy16));

  int tests = 0;
  int fails = 0;
  int rx = 0;

  typedef struct {
    logic [63:0] ops;
    logic [10:0] exp_u;
    logic [10:0] exp_s;
  } vec_t;
  vec_t tbl [8];

  typedef struct {
    logic [10:0] u;
    logic [10:0] s;
  } exp_t;
  exp_t q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [10:0] ref_sum(input logic [63:0] v, input bit sgn);
    logic [10:0] acc;
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      if (sgn) acc = acc + {{3{v[8*k+7]}}, v[8*k +: 8]};
      else     acc = acc + {3'b000, v[8*k +: 8]};
    end
    return acc;
  endfunction

  // One clock of stimulus; scoreboard push on accept, compare on consume.
  task automatic cycle(input logic v, input logic [63:0] d, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    ops       = d;
    out_ready = ordy;
    #1;
    if (v && in_ready_u) begin
      e.u = ref_sum(d, 1'b0);
      e.s = ref_sum(d, 1'b1);
      q.push_back(e);
    end
    if (ov_u && ordy) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL spurious: out_valid with nothing outstanding, sum=%0d", sum_u);
      end else begin
        e = q.pop_front();
        rx++;
        if (sum_u !== e.u || sum_s !== e.s) begin
          fails++;
          $display("FAIL stream: got u=0x%0h s=0x%0h want u=0x%0h s=0x%0h", sum_u, sum_s, e.u, e.s);
        end else begin
          $display("[TB] result %0d: u=0x%0h s=0x%0h", rx, sum_u, sum_s);
        end
      end
    end
  endtask

  task automatic send_table(input int i);
    int lat;
    @(negedge clk);
    ops      = tbl[i].ops;
    in_valid = 1'b1;
    #1;
    chk("tbl_in_ready", in_ready_u, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!ov_u && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("[TB] vec %0d ops=0x%h lat=%0d u=0x%0h s=0x%0h", i, tbl[i].ops, lat, sum_u, sum_s);
    chk("tbl_latency", lat, 3);
    chk("tbl_sum_u", sum_u, tbl[i].exp_u);
    chk("tbl_valid_s", ov_s, 1);
    chk("tbl_sum_s", sum_s, tbl[i].exp_s);
  endtask

  task automatic send_wide(input logic [7:0] val, input logic [9:0] e4, input logic [11:0] e16);
    int lat, l4, l16;
    logic [9:0]  s4;
    logic [11:0] s16;
    @(negedge clk);
    ops4  = {4{val}};
    ops16 = {16{val}};
    iv4   = 1'b1;
    iv16  = 1'b1;
    #1;
    chk("wide_in_ready4", ir4, 1);
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    iv16 = 1'b0;
    lat = 0; l4 = -1; l16 = -1; s4 = '0; s16 = '0;
    while ((l4 < 0 || l16 < 0) && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (ov4 && l4 < 0) begin l4 = lat; s4 = sum4; end
      if (ov16 && l16 < 0) begin l16 = lat; s16 = sum16; end
    end
    $display("[TB] wide ops=0x%0h n4: lat=%0d sum=%0d n16: lat=%0d sum=%0d", val, l4, s4, l16, s16);
    chk("n4_latency", l4, 2);
    chk("n4_sum", s4, e4);
    chk("n16_latency", l16, 4);
    chk("n16_sum", s16, e16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 11'h7F8, 11'h7F8};
    tbl[1] = '{64'h8080_8080_8080_8080, 11'h400, 11'h400};
    tbl[2] = '{64'hFC04_FD03_FE02_FF01, 11'h400, 11'h000};
    tbl[3] = '{64'h0000_0000_0000_0000, 11'h000, 11'h000};
    tbl[4] = '{64'h0807_0605_0403_0201, 11'd36,  11'd36};
    tbl[5] = '{64'h7F7F_7F7F_7F7F_7F7F, 11'h3F8, 11'h3F8};
    tbl[6] = '{64'h0000_0000_0000_00FF, 11'd255, 11'h7FF};
    tbl[7] = '{64'h0000_0000_0000_7F80, 11'd255, 11'h7FF};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", ov_u, 0);
    chk("reset_busy", busy_u, 0);
    chk("reset_sum", sum_u, 0);
    chk("reset_in_ready", in_ready_u, 1);

    // Release just after an edge so the first vector lands on the very next edge.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_table(i);

    send_wide(8'h01, 10'd4, 12'd16);
    send_wide(8'hFF, 10'd1020, 12'd4080);

    rx = 0;
    for (int i = 0; i < 100; i++) cycle(1'b1, {$urandom, $urandom}, 1'b1);
    repeat (6) cycle(1'b0, 64'h0, 1'b1);
    chk("stream_count", rx, 100);

    // Stall with A at the output and B, C still in the pipe; D offered throughout.
    rx = 0;
    cycle(1'b1, 64'h0101_0101_0101_0101, 1'b1);
    cycle(1'b1, 64'h0202_0202_0202_0202, 1'b1);
    cycle(1'b1, 64'hF0E0_D0C0_B0A0_9080, 1'b0);
    cycle(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 64'h1111_2222_3333_4444, 1'b0);
      chk("stall_in_ready", in_ready_u, 0);
      chk("stall_out_valid", ov_u, 1);
      chk("stall_sum", sum_u, (q.size() > 0) ? q[0].u : 11'h0);
    end
    cycle(1'b1, 64'h1111_2222_3333_4444, 1'b1);
    repeat (6) cycle(1'b0, 64'h0, 1'b1);
    chk("stall_count", rx, 4);

    // Reset with two tokens in flight must discard them.
    cycle(1'b1, 64'h0505_0505_0505_0505, 1'b1);
    cycle(1'b1, 64'h0606_0606_0606_0606, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_reset_busy", busy_u, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", ov_u, 0);
    chk("abort_busy", busy_u, 0);
    chk("abort_sum", sum_u, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx = 0;
    repeat (6) cycle(1'b0, 64'h0, 1'b1);
    chk("abort_no_stale", rx, 0);
    cycle(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
    repeat (5) cycle(1'b0, 64'h0, 1'b1);
    chk("post_reset_count", rx, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/moa_cprs_tree.md
MOA_CPRS_TREE -- requirements
Module: moa_cprs_tree

Interface
REQ-001 Parameter NUM_OPS, default 8, number of operands; legal values 4, 8, 16.
REQ-002 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-003 Parameter SIGNED, default 0; 0 = unsigned operands, 1 = two's-complement operands.
REQ-004 Derived constant OW = WIDTH + log2(NUM_OPS), result width; LAT = log2(NUM_OPS), latency in cycles.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  operand vector valid.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 ops_i  input  NUM_OPS*WIDTH  packed operands, operand k at bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum_o  output  OW  registered sum of all operands.
REQ-013 busy  output  1  high when any pipeline stage holds a valid token.

Function
REQ-014 Operands SHALL be extended to OW bits (sign-extended if SIGNED=1, zero-extended otherwise) before compression.
REQ-015 Reduction SHALL use levels of 4:2 compressors (5 inputs incl. horizontal cin, outputs sum/carry/cout, cout chained to next bit's cin, bit 0 cin = 0); LAT-1 levels reduce NUM_OPS rows to 2 rows.
REQ-016 Each compressor level SHALL be followed by a pipeline register holding its rows plus one valid bit.
REQ-017 Final stage SHALL add the two remaining rows with a carry-propagate adder into the sum_o register; arithmetic modulo 2^OW, no overflow possible.
REQ-018 Latency SHALL be exactly LAT cycles from an accepted input (in_valid && in_ready at edge t) to out_valid at edge t+LAT when unstalled.
REQ-019 Global advance enable en = !out_valid || out_ready; all stage registers, valid bits and sum_o SHALL update only when en = 1.
REQ-020 in_ready SHALL equal en (combinational); throughput one vector per cycle when out_ready held high.
REQ-021 When en = 1 and in_valid = 0, a bubble (valid = 0) SHALL enter stage 1; data registers of invalid stages are don't-care.
REQ-022 While out_valid && !out_ready, sum_o and out_valid SHALL hold stable and no input SHALL be accepted.
REQ-023 busy SHALL be the OR of all stage valid bits including out_valid.
REQ-024 No combinational path from in_valid or ops_i to any output; out_ready -> in_ready is the only combinational path.

Reset
REQ-025 On rst_n low, all valid bits, out_valid, busy and sum_o SHALL clear to 0 asynchronously; stage data registers SHALL clear to 0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight tokens; no result from before reset SHALL ever appear.
REQ-027 First input SHALL be accepted on the first rising edge after rst_n deasserts (in_ready = 1 since out_valid = 0).

Structure
REQ-028 Package moa_pkg SHALL hold the legal NUM_OPS check, the OW/LAT derivation functions and the compressor-level count function.
REQ-029 One sub-module cprs_4_2_cell (single-bit 4:2 compressor, combinational) SHALL be instantiated per bit per compressor group via generate.
REQ-030 Illegal parameter values SHALL fail elaboration.

Verification (NUM_OPS=8, WIDTH=8, LAT=3, OW=11 unless stated)
REQ-031 SIGNED=0, all ops = 255, out_ready = 1 -> out_valid at edge t+3, sum_o = 2040 (0x7F8).
REQ-032 SIGNED=1, all ops = 0x80 (-128) -> sum_o = 0x400 (-1024); ops = {1,-1,2,-2,3,-3,4,-4} -> sum_o = 0.
REQ-033 Back-to-back 100 random vectors, out_ready = 1 -> 100 results in order, one per cycle, each equal to reference sum mod 2^11.
REQ-034 out_ready low 5 cycles with 3 tokens in flight -> in_ready = 0, sum_o/out_valid stable, no token lost or duplicated after release.
REQ-035 rst_n pulsed low while 2 tokens in flight -> out_valid = 0, busy = 0 immediately; no stale result after release.
REQ-036 NUM_OPS=4 and NUM_OPS=16 builds, ops all 1 -> sum_o = 4 at LAT=2, sum_o = 16 at LAT=4.
